// File: rtl/udm_cmd_decoder_pkg.sv
// Shared definitions for the UDM command decoder: framing bytes, command codes,
// FSM state encoding and small byte-lane helpers.
package udm_cmd_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'h55;
    localparam logic [7:0] ESCAPE_BYTE = 8'h5A;

    typedef enum logic [7:0] {
        CMD_IDCODE   = 8'h00,
        CMD_RST      = 8'h80,
        CMD_NRST     = 8'hC0,
        CMD_WR       = 8'h81,
        CMD_RD       = 8'h82,
        CMD_WR_NOINC = 8'h83,
        CMD_RD_NOINC = 8'h84
    } udm_cmd_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_LEN    = 3'd3;
    localparam logic [2:0] ST_WDATA  = 3'd4;
    localparam logic [2:0] ST_BUS_WR = 3'd5;
    localparam logic [2:0] ST_BUS_RD = 3'd6;
    localparam logic [2:0] ST_TX     = 3'd7;

    // Little-endian byte lane insert: idx 0 is the first byte on the wire.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/udm_cmd_decoder_if.sv
// Single-outstanding bus master/slave connection driven by the UDM decoder.
interface udm_cmd_decoder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, resp, rdata
    );

endinterface

// File: rtl/udm_cmd_decoder_unescape.sv
// Strips UDM escape framing from the rx byte stream; flags unescaped SYNC bytes
// separately from literal data bytes in the same cycle the byte arrives.
module udm_cmd_decoder_unescape
    import udm_cmd_decoder_pkg::*;
(
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       is_sync_o
);

    logic esc_q, esc_d;

    always_comb begin
        byte_valid_o = rx_valid_i &&
                       (esc_q || ((rx_data_i != SYNC_BYTE) && (rx_data_i != ESCAPE_BYTE)));
        is_sync_o    = rx_valid_i && !esc_q && (rx_data_i == SYNC_BYTE);
        byte_o       = rx_data_i;
        esc_d        = esc_q;
        if (rx_valid_i) begin
            esc_d = !esc_q && (rx_data_i == ESCAPE_BYTE);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            esc_q <= 1'b0;
        end else begin
            esc_q <= esc_d;
        end
    end

endmodule

// File: rtl/udm_cmd_decoder.sv
// Target-side UDM protocol engine: decodes framed commands from the UART byte
// stream, runs single-outstanding bus transfers and returns read/IDCODE bytes.
module udm_cmd_decoder
    import udm_cmd_decoder_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h55AA_0001,
    parameter logic [15:0] BUS_TIMEOUT = 16'd1024
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    output logic       rst_o,
    output logic       err_o,
    udm_cmd_decoder_if.master bus
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       is_sync;

    udm_cmd_decoder_unescape u_unescape (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .byte_valid_o(byte_valid),
        .byte_o      (rx_byte),
        .is_sync_o   (is_sync)
    );

    logic [2:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [29:0] count_q, count_d;
    logic        inc_q, inc_d;
    logic        is_wr_q, is_wr_d;
    logic        is_id_q, is_id_d;
    logic        acked_q, acked_d;
    logic        abort_q, abort_d;
    logic        err_q, err_d;
    logic        rst_q, rst_d;
    logic [15:0] tmo_q, tmo_d;

    logic tmo_hit;
    logic count_last;
    logic busy_d;

    assign tmo_hit    = (BUS_TIMEOUT != 16'd0) && (tmo_q == BUS_TIMEOUT - 16'd1);
    assign count_last = (count_q == 30'd1);

    // Two stages per cycle: first retire any bus/TX completion, then evaluate
    // the incoming byte against the state that completion produced.
    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path
        // through the case statements can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        inc_d   = inc_q;
        is_wr_d = is_wr_q;
        is_id_d = is_id_q;
        acked_d = acked_q;
        abort_d = abort_q;
        err_d   = err_q;
        rst_d   = rst_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_BUS_WR: begin
                if (bus.ack) begin
                    tmo_d   = '0;
                    count_d = count_q - 30'd1;
                    if (inc_q) addr_d = addr_q + 32'd4;
                    if (abort_q) begin
                        state_d = ST_CMD;
                        abort_d = 1'b0;
                        err_d   = 1'b0;
                    end else if (count_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    abort_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_BUS_RD: begin
                if (bus.resp && (acked_q || bus.ack)) begin
                    tmo_d   = '0;
                    acked_d = 1'b0;
                    data_d  = bus.rdata;
                    idx_d   = 2'd0;
                    state_d = ST_TX;
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    acked_d = 1'b0;
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    abort_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                    if (bus.ack) acked_d = 1'b1;
                end
            end
            ST_TX: begin
                if (tx_ready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (!is_id_q) begin
                            count_d = count_q - 30'd1;
                            if (inc_q) addr_d = addr_q + 32'd4;
                        end
                        if (abort_q) begin
                            state_d = ST_CMD;
                            abort_d = 1'b0;
                            err_d   = 1'b0;
                        end else if (is_id_q || count_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BUS_RD;
                        end
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d == ST_BUS_WR) || (state_d == ST_BUS_RD) || (state_d == ST_TX);

        if (is_sync) begin
            if (busy_d) begin
                abort_d = 1'b1;
            end else begin
                state_d = ST_CMD;
                idx_d   = 2'd0;
                err_d   = 1'b0;
            end
        end else if (byte_valid) begin
            case (state_d)
                ST_CMD: begin
                    idx_d = 2'd0;
                    case (rx_byte)
                        CMD_IDCODE: begin
                            data_d  = IDCODE;
                            is_id_d = 1'b1;
                            state_d = ST_TX;
                        end
                        CMD_RST: begin
                            rst_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                        CMD_NRST: begin
                            rst_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                        CMD_WR, CMD_WR_NOINC: begin
                            is_wr_d = 1'b1;
                            is_id_d = 1'b0;
                            inc_d   = (rx_byte == CMD_WR);
                            state_d = ST_ADDR;
                        end
                        CMD_RD, CMD_RD_NOINC: begin
                            is_wr_d = 1'b0;
                            is_id_d = 1'b0;
                            inc_d   = (rx_byte == CMD_RD);
                            state_d = ST_ADDR;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_ADDR: begin
                    addr_d = put_byte(addr_d, idx_d, rx_byte);
                    if (idx_d == 2'd3) state_d = ST_LEN;
                    idx_d = idx_d + 2'd1;
                end
                ST_LEN: begin
                    data_d = put_byte(data_d, idx_d, rx_byte);
                    if (idx_d == 2'd3) begin
                        count_d = data_d[31:2];
                        if (count_d == 30'd0) state_d = ST_IDLE;
                        else if (is_wr_q)     state_d = ST_WDATA;
                        else                  state_d = ST_BUS_RD;
                    end
                    idx_d = idx_d + 2'd1;
                end
                ST_WDATA: begin
                    data_d = put_byte(data_d, idx_d, rx_byte);
                    if (idx_d == 2'd3) state_d = ST_BUS_WR;
                    idx_d = idx_d + 2'd1;
                end
                ST_BUS_WR, ST_BUS_RD, ST_TX: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // same pre-edge values; all registers, including the data word, reset here.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            inc_q   <= 1'b0;
            is_wr_q <= 1'b0;
            is_id_q <= 1'b0;
            acked_q <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            rst_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            inc_q   <= inc_d;
            is_wr_q <= is_wr_d;
            is_id_q <= is_id_d;
            acked_q <= acked_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            rst_q   <= rst_d;
            tmo_q   <= tmo_d;
        end
    end

    assign tx_valid_o = (state_q == ST_TX);
    assign tx_data_o  = get_byte(data_q, idx_q);
    assign rst_o      = rst_q;
    assign err_o      = err_q;
    assign bus.req    = (state_q == ST_BUS_WR) || ((state_q == ST_BUS_RD) && !acked_q);
    assign bus.we     = (state_q == ST_BUS_WR);
    assign bus.addr   = addr_q;
    assign bus.wdata  = data_q;

endmodule
